// File: rtl/mips_regfile_mp.sv
// rtl/mips_regfile_mp.sv - Multi-port MIPS register file with write bypass and busy scoreboard
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              rsv_ok;
    logic [ADDR_W-1:0] ra;

    // Operations aimed at a hardwired zero register are dropped before they reach any state.
    assign wr0_ok = wr0_en && !(ZERO_REG && (wr0_addr == '0));
    assign wr1_ok = wr1_en && !(ZERO_REG && (wr1_addr == '0));
    assign rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == '0));

    // Reserve is applied after the write clears so a new producer stays outstanding.
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[wr0_addr] = 1'b0;
        if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
        cnt_nxt = '0;
        for (int j = 0; j < DEPTH; j++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[j]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            // Port 1 is assigned last so it wins an address collision with port 0.
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rd_data[i*DATA_W +: DATA_W] = regs[ra];
            rd_busy[i]                  = busy[ra];
            if (BYPASS) begin
                if (wr1_ok && (wr1_addr == ra)) begin
                    rd_data[i*DATA_W +: DATA_W] = wr1_data;
                    rd_busy[i]                  = 1'b0;
                end else if (wr0_ok && (wr0_addr == ra)) begin
                    rd_data[i*DATA_W +: DATA_W] = wr0_data;
                    rd_busy[i]                  = 1'b0;
                end
            end
            if ((ZERO_REG && (ra == '0)) || rst) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_busy[i]                  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// tb/tb_mips_regfile_mp.sv - Scoreboard bench for mips_regfile_mp across three parameter sets
module tb_mips_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  s_rd [4];
    logic        s_w0en, s_w1en, s_rsven;
    logic [4:0]  s_w0a, s_w1a, s_rsva;
    logic [31:0] s_w0d, s_w1d;

    logic [63:0] a_rd_data, b_rd_data, c_rd_data;
    logic [1:0]  a_rd_busy, b_rd_busy;
    logic [3:0]  c_rd_busy;
    logic [5:0]  a_cnt, b_cnt;
    logic [3:0]  c_cnt;

    // Model 0: default parameters. Model 1: no bypass, no zero register. Model 2: narrow, 4 read ports.
    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr({s_rd[1], s_rd[0]}), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr0_en(s_w0en), .wr0_addr(s_w0a), .wr0_data(s_w0d),
        .wr1_en(s_w1en), .wr1_addr(s_w1a), .wr1_data(s_w1d),
        .rsv_en(s_rsven), .rsv_addr(s_rsva), .busy_cnt(a_cnt));

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr({s_rd[1], s_rd[0]}), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr0_en(s_w0en), .wr0_addr(s_w0a), .wr0_data(s_w0d),
        .wr1_en(s_w1en), .wr1_addr(s_w1a), .wr1_data(s_w1d),
        .rsv_en(s_rsven), .rsv_addr(s_rsva), .busy_cnt(b_cnt));

    mips_regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_c (
        .clk(clk), .rst(rst),
        .rd_addr({s_rd[3][2:0], s_rd[2][2:0], s_rd[1][2:0], s_rd[0][2:0]}),
        .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr0_en(s_w0en), .wr0_addr(s_w0a[2:0]), .wr0_data(s_w0d[15:0]),
        .wr1_en(s_w1en), .wr1_addr(s_w1a[2:0]), .wr1_data(s_w1d[15:0]),
        .rsv_en(s_rsven), .rsv_addr(s_rsva[2:0]), .busy_cnt(c_cnt));

    typedef struct packed {
        logic [2:0][3:0][31:0] d;
        logic [2:0][3:0]       b;
        logic [2:0][5:0]       cnt;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mem [3][32];
    logic        bsy [3][32];
    int          errors = 0;
    int          checks = 0;

    function automatic int amask(int m);  return (m == 2) ? 7 : 31; endfunction
    function automatic logic [31:0] dmask(int m); return (m == 2) ? 32'h0000FFFF : 32'hFFFFFFFF; endfunction
    function automatic bit bp_of(int m);  return m != 1; endfunction
    function automatic bit zr_of(int m);  return m != 1; endfunction
    function automatic int nrd_of(int m); return (m == 2) ? 4 : 2; endfunction

    // A write or reserve that actually lands in model m at register a.
    function automatic bit lands(int m, logic en, logic [4:0] addr, int a);
        int x;
        x = int'(addr) & amask(m);
        return en && (x == a) && !(zr_of(m) && x == 0);
    endfunction

    function automatic logic [31:0] model_read(int m, int a);
        if (zr_of(m) && a == 0) return 32'h0;
        if (bp_of(m) && lands(m, s_w1en, s_w1a, a)) return s_w1d & dmask(m);
        if (bp_of(m) && lands(m, s_w0en, s_w0a, a)) return s_w0d & dmask(m);
        return mem[m][a];
    endfunction

    function automatic logic model_busy(int m, int a);
        if (bp_of(m) && (lands(m, s_w1en, s_w1a, a) || lands(m, s_w0en, s_w0a, a))) return 1'b0;
        return bsy[m][a];
    endfunction

    function automatic logic [5:0] model_cnt(int m);
        int n = 0;
        for (int a = 0; a <= amask(m); a++) n += int'(bsy[m][a]);
        return 6'(n);
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 3; m++)
            for (int a = 0; a < 32; a++) begin
                mem[m][a] = 32'h0;
                bsy[m][a] = 1'b0;
            end
    endtask

    task automatic issue(input logic [4:0] r0, r1, r2, r3,
                         input logic w0en, input logic [4:0] w0a, input logic [31:0] w0d,
                         input logic w1en, input logic [4:0] w1a, input logic [31:0] w1d,
                         input logic rsven, input logic [4:0] rsva);
        exp_t e;
        int   a;
        @(posedge clk); #1;
        s_rd[0] = r0; s_rd[1] = r1; s_rd[2] = r2; s_rd[3] = r3;
        s_w0en = w0en; s_w0a = w0a; s_w0d = w0d;
        s_w1en = w1en; s_w1a = w1a; s_w1d = w1d;
        s_rsven = rsven; s_rsva = rsva;
        e = '0;
        for (int m = 0; m < 3; m++) begin
            for (int p = 0; p < nrd_of(m); p++) begin
                a = int'(s_rd[p]) & amask(m);
                e.d[m][p] = model_read(m, a);
                e.b[m][p] = model_busy(m, a);
            end
            e.cnt[m] = model_cnt(m);
        end
        sb_q.push_back(e);
        for (int m = 0; m < 3; m++) begin
            if (lands(m, w0en, w0a, int'(w0a) & amask(m))) begin
                mem[m][int'(w0a) & amask(m)] = w0d & dmask(m);
                bsy[m][int'(w0a) & amask(m)] = 1'b0;
            end
            if (lands(m, w1en, w1a, int'(w1a) & amask(m))) begin
                mem[m][int'(w1a) & amask(m)] = w1d & dmask(m);
                bsy[m][int'(w1a) & amask(m)] = 1'b0;
            end
            if (lands(m, rsven, rsva, int'(rsva) & amask(m)))
                bsy[m][int'(rsva) & amask(m)] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] r0, r1, r2, r3);
        issue(r0, r1, r2, r3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    // Reset asserted between edges and released before the next edge; everything reads 0 meanwhile.
    task automatic reset_pulse();
        @(posedge clk); #1;
        s_w0en = 1'b0; s_w1en = 1'b0; s_rsven = 1'b0;
        rst = 1'b1;
        sb_q.push_back('0);
        model_clear();
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check(input string name, input int m, input int p, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s model%0d port%0d at %0t: got %h expected %h", name, m, p, $time, act, exp);
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int p = 0; p < 2; p++) begin
                check("rd_data", 0, p, a_rd_data[p*32 +: 32], e.d[0][p]);
                check("rd_data", 1, p, b_rd_data[p*32 +: 32], e.d[1][p]);
                check("rd_busy", 0, p, {31'b0, a_rd_busy[p]}, {31'b0, e.b[0][p]});
                check("rd_busy", 1, p, {31'b0, b_rd_busy[p]}, {31'b0, e.b[1][p]});
            end
            for (int p = 0; p < 4; p++) begin
                check("rd_data", 2, p, {16'b0, c_rd_data[p*16 +: 16]}, e.d[2][p]);
                check("rd_busy", 2, p, {31'b0, c_rd_busy[p]}, {31'b0, e.b[2][p]});
            end
            check("busy_cnt", 0, 0, {26'b0, a_cnt}, {26'b0, e.cnt[0]});
            check("busy_cnt", 1, 0, {26'b0, b_cnt}, {26'b0, e.cnt[1]});
            check("busy_cnt", 2, 0, {28'b0, c_cnt}, {26'b0, e.cnt[2]});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1;
        for (int p = 0; p < 4; p++) s_rd[p] = 5'd0;
        s_w0en = 0; s_w0a = 0; s_w0d = 0; s_w1en = 0; s_w1a = 0; s_w1d = 0; s_rsven = 0; s_rsva = 0;
        model_clear();
        repeat (2) @(negedge clk);
        // Reset state with rst held.
        sb_q.push_back('0);
        @(negedge clk); #1;
        rst = 1'b0;

        idle(5'd0, 5'd11, 5'd3, 5'd7);
        issue(5'd11, 5'd11, 5'd11, 5'd3, 1, 5'd11, 32'h3000001F, 0, 5'd0, 32'h0, 0, 5'd0);
        idle(5'd11, 5'd11, 5'd3, 5'd11);

        issue(5'd7, 5'd7, 5'd7, 5'd7, 1, 5'd7, 32'h000003FF, 1, 5'd7, 32'hDEADBEEF, 0, 5'd0);
        idle(5'd7, 5'd7, 5'd7, 5'd0);

        issue(5'd0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 5'd0);
        idle(5'd0, 5'd0, 5'd0, 5'd0);

        issue(5'd5, 5'd9, 5'd5, 5'd1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5);
        issue(5'd5, 5'd9, 5'd5, 5'd1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9);
        issue(5'd5, 5'd9, 5'd5, 5'd1, 0, 5'd0, 32'h0, 1, 5'd5, 32'h0000AB05, 0, 5'd0);
        issue(5'd5, 5'd9, 5'd5, 5'd1, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 5'd9);
        idle(5'd5, 5'd9, 5'd5, 5'd1);

        issue(5'd2, 5'd5, 5'd2, 5'd5, 1, 5'd2, 32'h12345678, 0, 5'd0, 32'h0, 1, 5'd5);
        idle(5'd2, 5'd5, 5'd2, 5'd5);
        reset_pulse();
        issue(5'd2, 5'd4, 5'd2, 5'd4, 1, 5'd4, 32'hCAFE0004, 0, 5'd0, 32'h0, 0, 5'd0);
        idle(5'd4, 5'd2, 5'd4, 5'd5);

        reset_pulse();
        for (int r = 1; r < 8; r++)
            issue(5'(r), 5'(r), 5'(r), 5'(r), 1, 5'(r), 32'h1000 * r + 32'h11 * r, 0, 5'd0, 32'h0, 0, 5'd0);
        idle(5'd1, 5'd2, 5'd3, 5'd4);
        idle(5'd5, 5'd6, 5'd7, 5'd1);
        for (int r = 1; r < 8; r++)
            issue(5'd1, 5'd2, 5'd3, 5'd4, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'(r));
        idle(5'd5, 5'd6, 5'd7, 5'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) reset_pulse();
            else issue(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr(),
                       1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                       1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                       1'($urandom_range(0, 1)), rnd_addr());
        end
        idle(5'd1, 5'd2, 5'd3, 5'd4);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised successor to the MIPS register file: configurable data width, depth and read-port count, two write ports with fixed priority, optional same-cycle write-to-read bypass, hardwired zero register, and a per-register busy scoreboard for multicycle producers. Sits in the decode stage of the MIPS datapath. Read ports feed operand fetch. Write port 0 takes the normal writeback path, and write port 1 takes late or multicycle writebacks (mul/div, loads). The scoreboard lets decode stall on registers with an outstanding producer.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a write in the current cycle is visible on matching read ports in the same cycle; 0 = reads return only stored values
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and reserves

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational; port i occupies bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address, combinational
- wr0_en  in  1  write enable, port 0
- wr0_addr  in  ADDR_W  write address, port 0
- wr0_data  in  DATA_W  write data, port 0
- wr1_en  in  1  write enable, port 1; has priority over port 0
- wr1_addr  in  ADDR_W  write address, port 1
- wr1_data  in  DATA_W  write data, port 1
- rsv_en  in  1  reserve: marks rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- busy_cnt  out  ADDR_W+1  number of busy registers, registered

## Operation
- Storage: 2^ADDR_W × DATA_W registers, plus a 2^ADDR_W-bit busy vector.
- Reset (rst=1, asynchronous):
  - all registers, all busy bits and busy_cnt go to 0 immediately
  - rd_data reads 0 and rd_busy reads 0 while rst is held
  - writes and reserves are ignored while rst=1
- Write:
  - on the rising edge, each enabled port stores its data at its address
  - if wr0_en and wr1_en target the same address, wr1_data is stored
  - with ZERO_REG=1, writes to address 0 are dropped
- Read:
  - rd_data[i] = reg[rd_addr[i]]
  - with BYPASS=1, if an enabled write targets rd_addr[i] this cycle (and the address is not a dropped zero-register write), rd_data[i] returns that write data instead; wr1 takes precedence over wr0
  - with ZERO_REG=1, address 0 always reads 0
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge
  - any enabled write clears busy[wr_addr] at the edge
  - if a reserve and a write hit the same address in the same cycle, the reserve wins and the bit ends up set (a new producer is outstanding)
  - a reserve of an already-busy register leaves it set
  - with ZERO_REG=1, reserves of address 0 are ignored
- rd_busy[i] = busy[rd_addr[i]]. With BYPASS=1 it is forced to 0 when an enabled write to that address occurs in the same cycle.
- busy_cnt is the popcount of the busy vector, updated at the same edge as the vector. Range is 0..2^ADDR_W and it does not wrap.

## Timing
- Write latency: 1 edge to storage. Same-cycle visibility only when BYPASS=1.
- Reserve latency: 1 edge. rd_busy rises in the cycle after rsv_en.
- Read path is purely combinational from rd_addr, write ports and state. No read enable.
- Reset deasserted mid-sequence: the first rising edge after deassertion is a normal edge.

## Test plan
1. Reset, then write 0x3000001F to r11 via port 0. In the same cycle, read r11 with BYPASS=1 -> 0x3000001F; with BYPASS=0 -> 0x00000000. The next cycle reads 0x3000001F on both read ports.
2. Same-cycle conflict: wr0 writes 0x000003FF and wr1 writes 0xDEADBEEF, both to r7 -> r7 = 0xDEADBEEF; a same-cycle bypass read of r7 = 0xDEADBEEF.
3. Zero register:
   - write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, rd_busy = 0, busy_cnt = 0
   - with ZERO_REG=0, the same write -> r0 reads 0xFFFFFFFF
4. Scoreboard:
   - reserve r5, then r9 -> busy_cnt 1 then 2, rd_busy for r5 = 1
   - write r5 via wr1 -> r5 not busy, busy_cnt = 1
   - reserve r9 and write r9 in the same cycle -> r9 still busy, busy_cnt = 1
5. Asynchronous reset mid-operation: with r2 = 0x12345678 and r5 busy, pulse rst between clock edges -> rd_data = 0 and busy_cnt = 0 before the next edge; a write on the first edge after release succeeds.
6. Parameter sweep DATA_W=16, ADDR_W=3, NUM_RD=4: write a distinct value to each of r1..r7, then read all four ports concurrently -> each port returns its addressed value. Reserving all seven registers -> busy_cnt = 7.
